// File: rtl/mem_sdp_arb_pkg.sv
// Shared types and helpers for mem_sdp_arbiter.
// Optional feature macro: MEM_SDP_ARB_RAW_BYPASS_EN (read tags carry write data for same-cycle RAW).
package mem_sdp_arb_pkg;

    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned RR_PTR_W = 4;
`ifdef MEM_SDP_ARB_RAW_BYPASS_EN
    localparam int unsigned MAX_DATA_W = 64;
`endif

    // Read response tag: owner travels with the read until ram_dob is valid
    typedef struct packed {
        logic                  valid;
        logic [MAX_REQ-1:0]    owner;
`ifdef MEM_SDP_ARB_RAW_BYPASS_EN
        logic                  hit;
        logic [MAX_DATA_W-1:0] data;
`endif
    } rsp_tag_t;

    // Next round-robin pointer: one past the winner, wrapping at num_req
    function automatic logic [RR_PTR_W-1:0] rr_next_ptr(
        input logic [RR_PTR_W-1:0] winner,
        input int unsigned         num_req
    );
        logic [RR_PTR_W-1:0] nxt;
        nxt = winner + RR_PTR_W'(1);
        if ((32'(winner) + 32'd1) >= num_req) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_sdp_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer and combinational one-hot grant.
module rr_arbiter
    import mem_sdp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    logic [RR_PTR_W-1:0] ptr_q;
    logic [RR_PTR_W-1:0] ptr_d;
    logic [NUM_REQ-1:0]  req_hi;
    logic [RR_PTR_W-1:0] win_hi;
    logic [RR_PTR_W-1:0] win_lo;
    logic [RR_PTR_W-1:0] winner;
    logic                any_req;

    // Pick first requester at/after the pointer, else lowest requester (wrap-around)
    always_comb begin
        req_hi  = '0;
        win_hi  = '0;
        win_lo  = '0;
        gnt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_hi[i] = req[i] && (RR_PTR_W'(i) >= ptr_q);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_hi[i]) win_hi = RR_PTR_W'(i);
            if (req[i])    win_lo = RR_PTR_W'(i);
        end
        any_req = (|req) && !reset;
        winner  = (|req_hi) ? win_hi : win_lo;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = any_req && (winner == RR_PTR_W'(i));
        end
        ptr_d = any_req ? rr_next_ptr(winner, NUM_REQ) : ptr_q;
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_sdp_arbiter.sv
// Round-robin sharing of a simple dual-port RAM among NUM_REQ requesters,
// with independent write/read arbitration and tagged read-response routing.
// Optional feature macro: MEM_SDP_ARB_RAW_BYPASS_EN (same-cycle write data forwarded to read).
module mem_sdp_arbiter
    import mem_sdp_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 0,
    parameter int unsigned DEPTH        = 0,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned DW = (DATA_WIDTH > 0) ? DATA_WIDTH : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    wr_req,
    input  logic [NUM_REQ*AW-1:0] wr_addr,
    input  logic [NUM_REQ*DW-1:0] wr_data,
    output logic [NUM_REQ-1:0]    wr_gnt,
    input  logic [NUM_REQ-1:0]    rd_req,
    input  logic [NUM_REQ*AW-1:0] rd_addr,
    output logic [NUM_REQ-1:0]    rd_gnt,
    output logic [NUM_REQ-1:0]    rd_rsp_valid,
    output logic [DW-1:0]         rd_rsp_data,
    output logic                  ram_wea,
    output logic [AW-1:0]         ram_addra,
    output logic [DW-1:0]         ram_dia,
    output logic                  ram_reb,
    output logic [AW-1:0]         ram_addrb,
    input  logic [DW-1:0]         ram_dob
);

    // Elaboration-time parameter checks
    if (DATA_WIDTH == 0 || DEPTH < 2) begin : g_bad_size
        $fatal(1, "mem_sdp_arbiter: DATA_WIDTH and DEPTH must be set (DEPTH >= 2)");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_req
        $fatal(1, "mem_sdp_arbiter: NUM_REQ must be 2..16");
    end
    if (READ_LATENCY > 2) begin : g_bad_lat
        $fatal(1, "mem_sdp_arbiter: READ_LATENCY must be 0, 1 or 2");
    end
`ifdef MEM_SDP_ARB_RAW_BYPASS_EN
    if (DATA_WIDTH > MAX_DATA_W) begin : g_bad_bypass_w
        $fatal(1, "mem_sdp_arbiter: DATA_WIDTH too wide for bypass tag");
    end
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    // Write port: route the winner's address/data, zero when idle
    always_comb begin
        ram_addra = '0;
        ram_dia   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                ram_addra = wr_addr[i*AW +: AW];
                ram_dia   = wr_data[i*DW +: DW];
            end
        end
    end

    // Read port: route the winner's address, zero when idle
    always_comb begin
        ram_addrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_gnt[i]) begin
                ram_addrb = rd_addr[i*AW +: AW];
            end
        end
    end

    assign ram_wea = |wr_gnt;
    assign ram_reb = |rd_gnt;

    rsp_tag_t tag_in_c;
    rsp_tag_t tag_out_c;

    // Tag entering the pipeline this cycle
    always_comb begin
        tag_in_c       = '0;
        tag_in_c.valid = |rd_gnt;
        tag_in_c.owner = MAX_REQ'(rd_gnt);
`ifdef MEM_SDP_ARB_RAW_BYPASS_EN
        tag_in_c.hit   = ram_wea && ram_reb && (ram_addra == ram_addrb);
        tag_in_c.data  = MAX_DATA_W'(ram_dia);
`endif
    end

    if (READ_LATENCY == 0) begin : g_lat0
        assign tag_out_c = tag_in_c;
    end else begin : g_lat_pipe
        rsp_tag_t tag_q [READ_LATENCY];
        rsp_tag_t tag_d [READ_LATENCY];

        // Stage 1 takes the new grant, later stages shift unconditionally
        always_comb begin
            tag_d[0] = tag_in_c;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_d[s] = tag_q[s-1];
            end
        end

        // Tag pipeline registers; reset drops in-flight reads
        always_ff @(posedge clk) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                if (reset) begin
                    tag_q[s] <= '0;
                end else begin
                    tag_q[s] <= tag_d[s];
                end
            end
        end

        assign tag_out_c = tag_q[READ_LATENCY-1];
    end

    // Response routing and optional write-data bypass
    always_comb begin
        rd_rsp_valid = tag_out_c.valid ? tag_out_c.owner[NUM_REQ-1:0] : '0;
        rd_rsp_data  = ram_dob;
`ifdef MEM_SDP_ARB_RAW_BYPASS_EN
        if (tag_out_c.valid && tag_out_c.hit) begin
            rd_rsp_data = tag_out_c.data[DW-1:0];
        end
`endif
    end

    // Owner bits above NUM_REQ are always zero
    logic unused_tag_bits;
    assign unused_tag_bits = ^tag_out_c;

endmodule

// File: tb/tb_mem_sdp_arbiter.sv
// Scoreboard bench for mem_sdp_arbiter: three instances at READ_LATENCY 0, 1, 2 share one stimulus.
// Honors MEM_SDP_ARB_RAW_BYPASS_EN for the same-cycle read/write expectation.
module tb_mem_sdp_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned NR    = 4;
    localparam int unsigned NLAT  = 3;
`ifdef MEM_SDP_ARB_RAW_BYPASS_EN
    localparam logic [DW-1:0] RAW_EXP = 8'h22;
`else
    localparam logic [DW-1:0] RAW_EXP = 8'h11;
`endif

    typedef struct {
        logic [NR-1:0] owner;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     wr_req;
    logic [NR*AW-1:0]  wr_addr;
    logic [NR*DW-1:0]  wr_data;
    logic [NR-1:0]     rd_req;
    logic [NR*AW-1:0]  rd_addr;

    logic [NR-1:0]     wr_gnt_a      [NLAT];
    logic [NR-1:0]     rd_gnt_a      [NLAT];
    logic [NR-1:0]     rsp_valid_a   [NLAT];
    logic [DW-1:0]     rsp_data_a    [NLAT];
    logic              ram_wea_a     [NLAT];
    logic [AW-1:0]     ram_addra_a   [NLAT];
    logic [DW-1:0]     ram_dia_a     [NLAT];
    logic              ram_reb_a     [NLAT];
    logic [AW-1:0]     ram_addrb_a   [NLAT];
    logic [DW-1:0]     ram_dob_a     [NLAT];

    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    exp_t exp_q2 [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [DW-1:0] d1 [NR];
    exp_t mon_e;
    bit   mon_ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar l = 0; l < NLAT; l++) begin : g_lat
        mem_sdp_arbiter #(
            .DATA_WIDTH   (DW),
            .DEPTH        (DEPTH),
            .NUM_REQ      (NR),
            .READ_LATENCY (l)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .wr_req       (wr_req),
            .wr_addr      (wr_addr),
            .wr_data      (wr_data),
            .wr_gnt       (wr_gnt_a[l]),
            .rd_req       (rd_req),
            .rd_addr      (rd_addr),
            .rd_gnt       (rd_gnt_a[l]),
            .rd_rsp_valid (rsp_valid_a[l]),
            .rd_rsp_data  (rsp_data_a[l]),
            .ram_wea      (ram_wea_a[l]),
            .ram_addra    (ram_addra_a[l]),
            .ram_dia      (ram_dia_a[l]),
            .ram_reb      (ram_reb_a[l]),
            .ram_addrb    (ram_addrb_a[l]),
            .ram_dob      (ram_dob_a[l])
        );

        // External distributed RAM model: sync write, async read, l output registers
        logic [DW-1:0] mem   [DEPTH];
        logic [DW-1:0] dob_q [2];
        always @(posedge clk) begin
            if (ram_wea_a[l]) mem[ram_addra_a[l]] <= ram_dia_a[l];
            dob_q[0] <= mem[ram_addrb_a[l]];
            dob_q[1] <= dob_q[0];
        end
        if (l == 0) begin : g_dob0
            assign ram_dob_a[l] = mem[ram_addrb_a[l]];
        end else begin : g_dobn
            assign ram_dob_a[l] = dob_q[l-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        wr_req  = '0;
        rd_req  = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req[i]            = 1'b1;
        wr_addr[i*AW +: AW]  = a;
        wr_data[i*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_req[i]            = 1'b1;
        rd_addr[i*AW +: AW]  = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expected response for each latency instance flagged in mask
    task automatic push_rsp(input logic [NR-1:0] owner, input logic [DW-1:0] data,
                            input logic [2:0] mask);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.cyc   = cyc;
        if (mask[0]) exp_q0.push_back(e);
        if (mask[1]) exp_q1.push_back(e);
        if (mask[2]) exp_q2.push_back(e);
    endtask

    task automatic pop_exp(input int l, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{owner: '0, data: '0, cyc: 0};
        case (l)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Grant and RAM-enable checks for every instance, sampled mid-cycle
    task automatic chk_ports(input string tag, input logic [NR-1:0] ewg, input logic [NR-1:0] erg);
        @(negedge clk);
        for (int l = 0; l < NLAT; l++) begin
            chk($sformatf("%s L%0d wr_gnt", tag, l), 32'(wr_gnt_a[l]), 32'(ewg));
            chk($sformatf("%s L%0d rd_gnt", tag, l), 32'(rd_gnt_a[l]), 32'(erg));
            chk($sformatf("%s L%0d ram_wea", tag, l), 32'(ram_wea_a[l]), 32'(|ewg));
            chk($sformatf("%s L%0d ram_reb", tag, l), 32'(ram_reb_a[l]), 32'(|erg));
        end
    endtask

    // Monitor: pop and compare whenever an instance presents a response
    always @(negedge clk) begin
        for (int l = 0; l < NLAT; l++) begin
            if (rsp_valid_a[l] != '0) begin
                pop_exp(l, mon_e, mon_ok);
                if (!mon_ok) begin
                    chk($sformatf("L%0d unexpected rsp", l), 32'(rsp_valid_a[l]), 32'd0);
                end else begin
                    chk($sformatf("L%0d rsp_owner", l), 32'(rsp_valid_a[l]), 32'(mon_e.owner));
                    chk($sformatf("L%0d rsp_data", l), 32'(rsp_data_a[l]), 32'(mon_e.data));
                    chk($sformatf("L%0d rsp_cycle", l), 32'(cyc), 32'(mon_e.cyc + l));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required end before 5000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        d1[0] = 8'h44;
        d1[1] = 8'hA5;
        d1[2] = 8'h66;
        d1[3] = 8'h11;

        // Reset with every request high: nothing granted or issued
        clr();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            set_wr(i, AW'(i), DW'(8'hC0 + i));
            set_rd(i, AW'(i));
        end
        step();
        step();
        chk_ports("reset", '0, '0);
        for (int l = 0; l < NLAT; l++) begin
            chk($sformatf("reset L%0d rsp_valid", l), 32'(rsp_valid_a[l]), 32'd0);
            chk($sformatf("reset L%0d ram_addra", l), 32'(ram_addra_a[l]), 32'd0);
            chk($sformatf("reset L%0d ram_dia", l), 32'(ram_dia_a[l]), 32'd0);
            chk($sformatf("reset L%0d ram_addrb", l), 32'(ram_addrb_a[l]), 32'd0);
        end

        // Write fairness: all four write for 8 cycles, each re-requests after its grant
        step();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            clr();
            for (int i = 0; i < NR; i++) begin
                if (c > i) set_wr(i, AW'(4 + i), d1[i]);
                else       set_wr(i, AW'(i), DW'(8'hB0 + i));
            end
            chk_ports($sformatf("wr_rr c%0d", c), NR'(4'b0001 << (c % 4)), '0);
            chk($sformatf("wr_rr c%0d ram_addra", c), 32'(ram_addra_a[0]), 32'(c));
            chk($sformatf("wr_rr c%0d ram_dia", c), 32'(ram_dia_a[0]),
                (c < 4) ? 32'(8'hB0 + c) : 32'(d1[c-4]));
            step();
        end

        // Read latency: requester 2 reads address 5 (0xA5)
        clr();
        set_rd(2, AW'(5));
        push_rsp(4'b0100, 8'hA5, 3'b111);
        chk_ports("rd_lat", '0, 4'b0100);
        chk("rd_lat ram_addrb", 32'(ram_addrb_a[2]), 32'd5);
        step();

        // Back-to-back: requesters 1 (addr 1) and 3 (addr 6) alternate, pointer starts at 3
        clr();
        set_rd(1, AW'(1));
        set_rd(3, AW'(6));
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_rsp(4'b1000, 8'h66, 3'b111);
            else            push_rsp(4'b0010, 8'hB1, 3'b111);
            chk_ports($sformatf("b2b k%0d", k), '0, (k % 2 == 0) ? 4'b1000 : 4'b0010);
            step();
        end

        // Same-cycle write 0x22 and read of address 7 (holding 0x11)
        clr();
        set_wr(0, AW'(7), 8'h22);
        set_rd(2, AW'(7));
        push_rsp(4'b0100, RAW_EXP, 3'b111);
        chk_ports("raw", 4'b0001, 4'b0100);
        step();
        clr();
        set_rd(2, AW'(7));
        push_rsp(4'b0100, 8'h22, 3'b111);
        chk_ports("raw_next", '0, 4'b0100);
        step();

        // Reset one cycle after a read grant: the latency-2 response is dropped
        clr();
        set_rd(0, AW'(0));
        set_wr(2, AW'(8), 8'h88);
        push_rsp(4'b0001, 8'hB0, 3'b011);
        chk_ports("pre_rst", 4'b0100, 4'b0001);
        step();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            set_wr(i, AW'(9 + i), DW'(8'h90 + i));
            set_rd(i, AW'(i));
        end
        chk_ports("rst_mid", '0, '0);
        step();
        reset = 1'b0;
        push_rsp(4'b0001, 8'hB0, 3'b111);
        chk_ports("post_rst", 4'b0001, 4'b0001);
        step();

        // Drain outstanding responses, then confirm nothing was left unanswered
        clr();
        repeat (6) step();
        chk("L0 pending", 32'(exp_q0.size()), 32'd0);
        chk("L1 pending", 32'(exp_q1.size()), 32'd0);
        chk("L2 pending", 32'(exp_q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
